// File: rtl/node_mem_update_arbiter.sv
// rtl/node_mem_update_arbiter.sv - lane-2 / config-writer arbiter for node memory BRAM port B
// Optional statistics outputs enabled by defining ARB_STATS_EN.
module node_mem_update_arbiter #(
  parameter int NODE_WIDTH = 40,
  parameter int ADDR_WIDTH = 6,
  parameter int MAX_WAIT   = 8,
  parameter int WAIT_CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  RSTn,
  input  logic                  lane_valid_in,
  input  logic [ADDR_WIDTH-1:0] lane_addr_in,
  output logic                  lane_ready_out,
  input  logic                  cfg_req,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [NODE_WIDTH-1:0] cfg_data,
  output logic                  cfg_ack,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [NODE_WIDTH-1:0] mem_din,
  output logic                  busy
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]           stall_cycles,
  output logic [15:0]           write_count
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GAP = 2'd1,
    STALL    = 2'd2
  } state_t;

  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MAX_WAIT - 1);

  state_t                state;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [NODE_WIDTH-1:0] cap_data;
  logic                  issue;

  // A pending write only takes a slot the lane leaves empty this cycle.
  assign issue = (state != IDLE) && !lane_valid_in;

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      cap_addr       <= '0;
      cap_data       <= '0;
      lane_ready_out <= 1'b1;
      cfg_ack        <= 1'b0;
      mem_addr       <= '0;
      mem_we         <= 1'b0;
      mem_din        <= '0;
      busy           <= 1'b0;
    end else begin
      mem_addr <= lane_addr_in;
      mem_we   <= 1'b0;
      cfg_ack  <= 1'b0;
      if (issue) begin
        mem_addr       <= cap_addr;
        mem_we         <= 1'b1;
        mem_din        <= cap_data;
        cfg_ack        <= 1'b1;
        lane_ready_out <= 1'b1;
        busy           <= 1'b0;
        state          <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            // The ack cycle blocks re-capture of the same still-high request.
            if (cfg_req && !cfg_ack) begin
              cap_addr <= cfg_addr;
              cap_data <= cfg_data;
              wait_cnt <= '0;
              busy     <= 1'b1;
              state    <= WAIT_GAP;
            end
          end
          WAIT_GAP: begin
            if (wait_cnt == WAIT_LAST) begin
              lane_ready_out <= 1'b0;
              state          <= STALL;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          STALL: begin
            lane_ready_out <= 1'b0;
          end
          default: begin
            state          <= IDLE;
            busy           <= 1'b0;
            lane_ready_out <= 1'b1;
          end
        endcase
      end
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      stall_cycles <= '0;
      write_count  <= '0;
    end else begin
      if (!lane_ready_out && (stall_cycles != 16'hFFFF))
        stall_cycles <= stall_cycles + 16'd1;
      if (issue && (write_count != 16'hFFFF))
        write_count <= write_count + 16'd1;
    end
  end
`endif

endmodule
